// File: rtl/rotary_quad_multi.sv
// Multi-channel quadrature rotary decoder: synchronise, debounce, detect full
// detents, keep signed positions, and expose them over Avalon-MM with an interrupt.
module rotary_quad_multi #(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 16,
    parameter int FILT_LEN = 4
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [2*NUM_CH-1:0] rotary_in,
    output logic [NUM_CH-1:0]   rotary_cw,
    output logic [NUM_CH-1:0]   rotary_ccw,
    input  logic [3:0]          avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    output logic [31:0]         avs_readdata,
    output logic                irq
);
    localparam int               NB        = 2 * NUM_CH;
    localparam logic [7:0]       FILT_LAST = 8'(FILT_LEN - 1);
    localparam logic [CNT_W-1:0] POS_ONE   = CNT_W'(1);

    logic [NB-1:0]           sync1_r, sync2_r, filt_r, prev_r;
    logic [7:0]              fcnt_r [NB];
    logic signed [2:0]       phase_r [NUM_CH];
    logic signed [2:0]       phase_s [NUM_CH];
    logic [NUM_CH-1:0]       evt_cw_s, evt_ccw_s, evt_err_s;
    logic [NUM_CH-1:0]       evt_cw_r, evt_ccw_r, evt_err_r;
    logic [NUM_CH-1:0]       cw_r, ccw_r, err_pls_r;
    logic signed [CNT_W-1:0] pos_r [NUM_CH];
    logic [NUM_CH-1:0]       pend_r, err_r, irq_en_r;
    logic [NUM_CH-1:0]       pos_wr_s, pend_clr_s, err_clr_s;
    logic                    stat_wr_s, en_wr_s;
    logic [31:0]             rdata_s, readdata_r;
    logic                    irq_r;
    logic                    unused_s;

    assign rotary_cw    = cw_r;
    assign rotary_ccw   = ccw_r;
    assign avs_readdata = readdata_r;
    assign irq          = irq_r;
    assign unused_s     = ^avs_writedata;

    // Two-flop synchroniser followed by a per-bit persistence filter
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1_r <= {NB{1'b0}};
            sync2_r <= {NB{1'b0}};
            filt_r  <= {NB{1'b0}};
            for (int i = 0; i < NB; i++) fcnt_r[i] <= 8'd0;
        end else begin
            sync1_r <= rotary_in;
            sync2_r <= sync1_r;
            for (int i = 0; i < NB; i++) begin
                if (sync2_r[i] == filt_r[i]) begin
                    fcnt_r[i] <= 8'd0;
                end else if (fcnt_r[i] == FILT_LAST) begin
                    fcnt_r[i] <= 8'd0;
                    filt_r[i] <= sync2_r[i];
                end else begin
                    fcnt_r[i] <= fcnt_r[i] + 8'd1;
                end
            end
        end
    end

    // Detent tracking: phase counts net quarter steps since the last visit to 00,
    // so only a complete sequence ending at 00 produces a pulse.
    always_comb begin
        evt_cw_s  = {NUM_CH{1'b0}};
        evt_ccw_s = {NUM_CH{1'b0}};
        evt_err_s = {NUM_CH{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            phase_s[k] = phase_r[k];
            if ((filt_r[2*k +: 2] ^ prev_r[2*k +: 2]) == 2'b11) begin
                evt_err_s[k] = 1'b1;
                phase_s[k]   = 3'sd0;
            end else if (filt_r[2*k +: 2] != prev_r[2*k +: 2]) begin
                if (filt_r[2*k +: 2] == 2'b00) begin
                    evt_cw_s[k]  = (prev_r[2*k +: 2] == 2'b10) && (phase_r[k] == 3'sd3);
                    evt_ccw_s[k] = (prev_r[2*k +: 2] == 2'b01) && (phase_r[k] == -3'sd3);
                    phase_s[k]   = 3'sd0;
                end else begin
                    case ({prev_r[2*k +: 2], filt_r[2*k +: 2]})
                        4'b0001, 4'b0111, 4'b1110: phase_s[k] = phase_r[k] + 3'sd1;
                        default:                   phase_s[k] = phase_r[k] - 3'sd1;
                    endcase
                end
            end else begin
                phase_s[k] = phase_r[k];
            end
        end
    end

    // Decoder state and the two-stage event pipeline feeding the output pulses
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            prev_r    <= {NB{1'b0}};
            evt_cw_r  <= {NUM_CH{1'b0}};
            evt_ccw_r <= {NUM_CH{1'b0}};
            evt_err_r <= {NUM_CH{1'b0}};
            cw_r      <= {NUM_CH{1'b0}};
            ccw_r     <= {NUM_CH{1'b0}};
            err_pls_r <= {NUM_CH{1'b0}};
            for (int k = 0; k < NUM_CH; k++) phase_r[k] <= 3'sd0;
        end else begin
            prev_r    <= filt_r;
            evt_cw_r  <= evt_cw_s;
            evt_ccw_r <= evt_ccw_s;
            evt_err_r <= evt_err_s;
            cw_r      <= evt_cw_r;
            ccw_r     <= evt_ccw_r;
            err_pls_r <= evt_err_r;
            for (int k = 0; k < NUM_CH; k++) phase_r[k] <= phase_s[k];
        end
    end

    // Register write decode
    always_comb begin
        stat_wr_s = avs_write && (avs_address == 4'd8);
        en_wr_s   = avs_write && (avs_address == 4'd9);
        for (int k = 0; k < NUM_CH; k++) begin
            pos_wr_s[k]   = avs_write && (avs_address == 4'(k));
            pend_clr_s[k] = stat_wr_s && avs_writedata[k];
            err_clr_s[k]  = stat_wr_s && avs_writedata[16 + k];
        end
    end

    // Position counters; a bus write takes priority over a same-cycle detent
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int k = 0; k < NUM_CH; k++) pos_r[k] <= {CNT_W{1'b0}};
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (pos_wr_s[k]) begin
                    pos_r[k] <= avs_writedata[CNT_W-1:0];
                end else if (cw_r[k]) begin
                    pos_r[k] <= pos_r[k] + POS_ONE;
                end else if (ccw_r[k]) begin
                    pos_r[k] <= pos_r[k] - POS_ONE;
                end
            end
        end
    end

    // Sticky status bits (set beats clear), interrupt enables and the irq line
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pend_r   <= {NUM_CH{1'b0}};
            err_r    <= {NUM_CH{1'b0}};
            irq_en_r <= {NUM_CH{1'b0}};
            irq_r    <= 1'b0;
        end else begin
            pend_r <= (pend_r & ~pend_clr_s) | cw_r | ccw_r;
            err_r  <= (err_r & ~err_clr_s) | err_pls_r;
            if (en_wr_s) begin
                irq_en_r <= avs_writedata[NUM_CH-1:0];
            end
            irq_r <= |(pend_r & irq_en_r);
        end
    end

    // Read data mux
    always_comb begin
        rdata_s = 32'd0;
        case (avs_address)
            4'd8: begin
                for (int k = 0; k < NUM_CH; k++) begin
                    rdata_s[k]      = pend_r[k];
                    rdata_s[16 + k] = err_r[k];
                end
            end
            4'd9: begin
                for (int k = 0; k < NUM_CH; k++) rdata_s[k] = irq_en_r[k];
            end
            default: begin
                for (int k = 0; k < NUM_CH; k++) begin
                    rdata_s = rdata_s | ((avs_address == 4'(k)) ? 32'(pos_r[k]) : 32'd0);
                end
            end
        endcase
    end

    // Read data register with fixed latency of one cycle; holds between reads
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            readdata_r <= 32'd0;
        end else if (avs_read) begin
            readdata_r <= rdata_s;
        end
    end

endmodule

// File: tb/tb_rotary_quad_multi.sv
// Self-checking bench for rotary_quad_multi: directed scenarios plus random
// rotation checked against a quarter-step accumulation model.
module tb_rotary_quad_multi;
    localparam int NUM_CH   = 2;
    localparam int CNT_W    = 16;
    localparam int FILT_LEN = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  rot   = 4'd0;
    logic [1:0]  cw, ccw;
    logic [3:0]  addr  = 4'd0;
    logic        rd    = 1'b0;
    logic        wr    = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        irq;

    int total = 0;
    int bad   = 0;
    int cnt_cw [2] = '{0, 0};
    int cnt_ccw[2] = '{0, 0};
    int both_hi    = 0;

    // reference model
    int          ecw [2] = '{0, 0};
    int          eccw[2] = '{0, 0};
    logic [15:0] mpos[2];
    logic [1:0]  mst [2];
    int          macc[2];
    bit          mbroken[2];
    logic [1:0]  mpend, merr, men;
    logic [1:0]  gseq[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    always #5 clk = ~clk;

    rotary_quad_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .FILT_LEN(FILT_LEN)) dut (
        .clk_clk      (clk),
        .reset_reset_n(rst_n),
        .rotary_in    (rot),
        .rotary_cw    (cw),
        .rotary_ccw   (ccw),
        .avs_address  (addr),
        .avs_read     (rd),
        .avs_write    (wr),
        .avs_writedata(wdata),
        .avs_readdata (rdata),
        .irq          (irq)
    );

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (cw[k])            cnt_cw[k]++;
            if (ccw[k])           cnt_ccw[k]++;
            if (cw[k] && ccw[k])  both_hi++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic int gidx(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [31:0] sx(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mst[k] = 2'b00; macc[k] = 0; mbroken[k] = 1'b0; mpos[k] = 16'd0;
        end
        mpend = 2'b00; merr = 2'b00; men = 2'b00;
    endtask

    // A detent is a net four quarter steps in one direction between visits to 00.
    task automatic model_step(input int ch, input logic [1:0] nv);
        int d;
        if (nv == mst[ch]) return;
        d = (gidx(nv) - gidx(mst[ch]) + 4) % 4;
        if (d == 2) begin
            merr[ch] = 1'b1;
            mbroken[ch] = 1'b1;
        end else begin
            macc[ch] += (d == 1) ? 1 : -1;
        end
        if (nv == 2'b00) begin
            if (!mbroken[ch] && macc[ch] == 4) begin
                ecw[ch]++; mpos[ch] = mpos[ch] + 16'd1; mpend[ch] = 1'b1;
            end else if (!mbroken[ch] && macc[ch] == -4) begin
                eccw[ch]++; mpos[ch] = mpos[ch] - 16'd1; mpend[ch] = 1'b1;
            end
            macc[ch] = 0;
            mbroken[ch] = 1'b0;
        end
        mst[ch] = nv;
    endtask

    task automatic move(input int ch, input logic [1:0] nv, input int hold);
        rot[2*ch +: 2] = nv;
        model_step(ch, nv);
        repeat (hold) @(negedge clk);
    endtask

    task automatic move2(input logic [1:0] v0, input logic [1:0] v1, input int hold);
        rot = {v1, v0};
        model_step(0, v0);
        model_step(1, v1);
        repeat (hold) @(negedge clk);
    endtask

    task automatic detent_cw0();
        move(0, 2'b01, 10);
        move(0, 2'b11, 10);
        move(0, 2'b10, 10);
    endtask

    task automatic avs_wr(input logic [3:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic avs_rd(input logic [3:0] a, output logic [31:0] d);
        addr = a; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        d = rdata;
    endtask

    task automatic wait_pulse(input int ch, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cw[ch]) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] d;
        for (int k = 0; k < 2; k++) begin
            avs_rd(4'(k), d);
            chk($sformatf("%s_pos%0d", tag, k), d, sx(mpos[k]));
            chk($sformatf("%s_cwcnt%0d", tag, k), cnt_cw[k], ecw[k]);
            chk($sformatf("%s_ccwcnt%0d", tag, k), cnt_ccw[k], eccw[k]);
        end
        avs_rd(4'd8, d);
        chk({tag, "_status"}, d, {14'd0, merr, 14'd0, mpend});
        avs_rd(4'd9, d);
        chk({tag, "_irqen"}, d, {30'd0, men});
        chk({tag, "_irq"}, {31'd0, irq}, {31'd0, |(mpend & men)});
        chk({tag, "_exclusive"}, both_hi, 0);
    endtask

    initial begin
        logic [31:0] d;
        bit          seen;
        logic [1:0]  nv[2];
        int          r;

        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_cw", {30'd0, cw}, 32'd0);
        chk("rst_ccw", {30'd0, ccw}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("reset");

        // one clockwise detent on channel 0
        detent_cw0();
        move(0, 2'b00, 10);
        avs_rd(4'd0, d);
        chk("cw_pos0_abs", d, 32'h0000_0001);
        check_all("cw0");
        avs_wr(4'd8, 32'h00FF_00FF);
        mpend = 2'b00; merr = 2'b00;

        // ccw across the most-negative boundary on channel 1
        avs_wr(4'd1, 32'h0000_8000);
        mpos[1] = 16'h8000;
        avs_rd(4'd1, d);
        chk("pos1_preload", d, 32'hFFFF_8000);
        move(1, 2'b10, 10);
        move(1, 2'b11, 10);
        move(1, 2'b01, 10);
        move(1, 2'b00, 10);
        avs_rd(4'd1, d);
        chk("ccw_wrap_abs", d, 32'h0000_7FFF);
        check_all("ccw1");

        // 3-cycle glitch at 10 must not be accepted as a return to 00
        detent_cw0();
        rot[1:0] = 2'b00;
        repeat (3) @(negedge clk);
        rot[1:0] = 2'b10;
        repeat (12) @(negedge clk);
        check_all("glitch");
        move(0, 2'b00, 10);
        check_all("after_glitch");

        // interrupt timing and W1C behaviour
        avs_wr(4'd8, 32'h00FF_00FF);
        mpend = 2'b00; merr = 2'b00;
        avs_wr(4'd9, 32'h0000_0001);
        men = 2'b01;
        @(negedge clk);
        chk("irq_idle", {31'd0, irq}, 32'd0);
        detent_cw0();
        move(0, 2'b00, 0);
        wait_pulse(0, seen);
        chk("irq_pulse_seen", {31'd0, seen}, 32'd1);
        @(negedge clk);
        chk("irq_before_pend", {31'd0, irq}, 32'd0);
        @(negedge clk);
        chk("irq_after_pend", {31'd0, irq}, 32'd1);
        repeat (3) @(negedge clk);
        avs_wr(4'd8, 32'h0000_0001);
        mpend[0] = 1'b0;
        chk("irq_w1c_same", {31'd0, irq}, 32'd1);
        @(negedge clk);
        chk("irq_w1c_low", {31'd0, irq}, 32'd0);
        detent_cw0();
        move(0, 2'b00, 0);
        wait_pulse(0, seen);
        chk("set_vs_clr_seen", {31'd0, seen}, 32'd1);
        avs_wr(4'd8, 32'h0000_0001);
        repeat (4) @(negedge clk);
        check_all("set_wins");

        // position write coincident with a detent pulse
        detent_cw0();
        move(0, 2'b00, 0);
        wait_pulse(0, seen);
        chk("wr_wins_seen", {31'd0, seen}, 32'd1);
        avs_wr(4'd0, 32'h0000_1234);
        mpos[0] = 16'h1234;
        repeat (4) @(negedge clk);
        avs_rd(4'd0, d);
        chk("wr_wins_abs", d, 32'h0000_1234);
        repeat (2) @(negedge clk);
        chk("rdata_hold", rdata, 32'h0000_1234);
        check_all("wr_wins");

        // both bits changing together is an error, never a detent
        move(0, 2'b11, 12);
        avs_rd(4'd8, d);
        chk("err_bit16", {31'd0, d[16]}, 32'd1);
        check_all("double");
        move(0, 2'b00, 12);
        check_all("double_back");
        avs_wr(4'd8, 32'h00FF_00FF);
        mpend = 2'b00; merr = 2'b00;

        // unmapped addresses and bits beyond NUM_CH
        avs_wr(4'd2, 32'h0000_ABCD);
        avs_wr(4'd12, 32'hFFFF_FFFF);
        avs_wr(4'd9, 32'h0000_00FF);
        men = 2'b11;
        avs_rd(4'd2, d);
        chk("unmapped_2", d, 32'd0);
        avs_rd(4'd10, d);
        chk("unmapped_10", d, 32'd0);
        avs_rd(4'd15, d);
        chk("unmapped_15", d, 32'd0);
        check_all("unmapped");

        // random rotation on both channels
        for (int it = 0; it < 48; it++) begin
            for (int k = 0; k < 2; k++) begin
                r = $urandom_range(0, 7);
                if (r == 0)      nv[k] = mst[k] ^ 2'b11;
                else if (r < 5)  nv[k] = gseq[(gidx(mst[k]) + 1) % 4];
                else             nv[k] = gseq[(gidx(mst[k]) + 3) % 4];
            end
            move2(nv[0], nv[1], $urandom_range(6, 14));
            if (it % 12 == 11) begin
                repeat (12) @(negedge clk);
                check_all("rand");
                d = $urandom;
                avs_wr(4'(it % 2), d);
                mpos[it % 2] = d[15:0];
                d = $urandom;
                avs_wr(4'd8, d);
                mpend = mpend & ~d[1:0];
                merr  = merr & ~d[17:16];
            end
        end
        move2(2'b00, 2'b00, 14);
        check_all("rand_end");

        // reset in the middle of a detent discards the partial sequence
        detent_cw0();
        avs_rd(4'd9, d);
        rst_n = 1'b0;
        #1;
        chk("midrst_irqen_read", d, {30'd0, men});
        chk("midrst_rdata", rdata, 32'd0);
        chk("midrst_irq", {31'd0, irq}, 32'd0);
        chk("midrst_cw", {30'd0, cw}, 32'd0);
        rot = 4'b0010;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_step(0, 2'b10);
        repeat (12) @(negedge clk);
        move(0, 2'b00, 12);
        check_all("post_rst_partial");
        detent_cw0();
        move(0, 2'b00, 12);
        check_all("post_rst_full");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rotary_quad_multi.md
ROTARY_QUAD_MULTI -- requirements
Module: rotary_quad_multi

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, number of encoder channels (legal range 1..8).
REQ-002 The block SHALL have parameter CNT_W, default 16, signed position counter width (legal range 2..32).
REQ-003 The block SHALL have parameter FILT_LEN, default 4, cycles an input must hold stable before acceptance (legal range 1..255).
REQ-004 clk_clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset_reset_n  in  1  asynchronous active-low reset.
REQ-006 rotary_in  in  2*NUM_CH  raw encoder pins; channel k uses {B,A} = rotary_in[2k+1:2k].
REQ-007 rotary_cw  out  NUM_CH  one-cycle pulse per completed clockwise detent, per channel.
REQ-008 rotary_ccw  out  NUM_CH  one-cycle pulse per completed counter-clockwise detent, per channel.
REQ-009 avs_address  in  4  register word address.
REQ-010 avs_read / avs_write  in  1 each  Avalon-MM read/write strobes.
REQ-011 avs_writedata  in  32  write data.
REQ-012 avs_readdata  out  32  read data.
REQ-013 irq  out  1  level interrupt.

Function
REQ-014 Each rotary_in bit SHALL pass a 2-flop synchroniser before any other logic.
REQ-015 Per bit, a filter counter SHALL update the filtered value only after the synchronised value differs from it for FILT_LEN consecutive cycles; any cycle of agreement clears the counter.
REQ-016 Decoder states per channel: filtered {B,A}; clockwise Gray order 00->01->11->10->00.
REQ-017 Filtered change 10->00 SHALL pulse rotary_cw[k] for exactly one cycle, two cycles after the filtered update; 01->00 SHALL pulse rotary_ccw[k] likewise.
REQ-018 Other single-bit transitions SHALL produce no pulse; a transition changing both bits in one cycle SHALL produce no pulse and SHALL set ERR[k].
REQ-019 rotary_cw[k] and rotary_ccw[k] SHALL never be high in the same cycle.
REQ-020 POS[k] (CNT_W-bit two's complement) SHALL increment on each cw pulse and decrement on each ccw pulse, wrapping silently (max+1 -> min, min-1 -> max).
REQ-021 Register map: addresses 0..NUM_CH-1 = POS[k] sign-extended to 32 bits, read/write (write loads avs_writedata[CNT_W-1:0]); 8 = STATUS: bits[7:0] PEND, bits[23:16] ERR, read, write-1-to-clear; 9 = IRQ_EN bits[7:0], read/write; all other addresses read 0, writes ignored.
REQ-022 avs_readdata SHALL be valid exactly one cycle after avs_read (fixed read latency 1, no waitrequest); it SHALL hold its last value otherwise.
REQ-023 PEND[k] SHALL set on any cw or ccw pulse of channel k.
REQ-024 irq SHALL be registered: irq = OR over k of (PEND[k] AND IRQ_EN[k]), one cycle after the causing update.
REQ-025 Simultaneous POS write and detent event on the same channel: write wins, event discarded from POS, PEND still sets.
REQ-026 Simultaneous W1C and new set of the same PEND/ERR bit: set wins.
REQ-027 Bits for channels >= NUM_CH SHALL read 0 and ignore writes.

Reset
REQ-028 On reset_reset_n low, asynchronously: synchronisers, filtered values and filter counters to 0 (decoder state 00); POS, PEND, ERR, IRQ_EN to 0; rotary_cw, rotary_ccw, irq, avs_readdata to 0.
REQ-029 Reset asserted mid-detent SHALL discard the partial sequence; after release the first detent completes only from a full sequence starting at filtered 00.

Verification
REQ-030 Channel 0 driven 00->01->11->10->00, each step held 10 cycles, FILT_LEN=4 -> one rotary_cw[0] pulse, POS[0] reads 0x00000001, PEND[0]=1.
REQ-031 Channel 1 ccw detent with POS[1] preloaded to 0x8000 (CNT_W=16) -> POS[1] reads 0x00007FFF; rotary_ccw[1] one pulse.
REQ-032 A bit glitch of 3 cycles (FILT_LEN=4) mid-detent -> no filtered change, no pulse, POS unchanged.
REQ-033 IRQ_EN=0x1, cw detent on ch0 -> irq high one cycle after PEND sets; write 0x1 to STATUS -> irq low next cycle; same-cycle new event keeps PEND[0]=1.
REQ-034 Force both bits 00->11 in one cycle after filtering -> no pulse, STATUS bit16 reads 1.
REQ-035 Write POS[0]=0x1234 in the cycle a cw pulse occurs -> POS[0] reads 0x00001234.
